mop_scoreboard: RTL and testbench

Parametrised register scoreboard for the Musk core issue stage. Replaces the single-bit busy-mask check with per-register pending-writer counters, multiple writeback ports and a selectable WAW policy. Sits between decode/issue and the execute/writeback pipes. It gates issue of a micro-op until its register hazards clear, and holds the `rsyscall` barrier until the machine is drained.

---
 rtl/mop_scoreboard.sv | 129 ++++++++++++
 tb/tb_mop_scoreboard.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mop_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-writer counters,
// multi-port writeback release, WAW policy select and rsyscall drain barrier.
package mop_pkg;
  localparam int REG_FILE_SIZE = 16;

  typedef enum logic [4:0] {
    rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
    r8, r9, r10, r11, r12, r13, r14, r15,
    rnil, rip, rimm, rv0, rv8, rsyscall
  } reg_id_t;

  function automatic logic reg_in_file(input logic [4:0] id);
    return id < 5'(REG_FILE_SIZE);
  endfunction

  function automatic logic [3:0] reg_num(input logic [4:0] id);
    return id[3:0];
  endfunction
endpackage

module mop_scoreboard
  import mop_pkg::*;
#(
  parameter int NREGS     = REG_FILE_SIZE,
  parameter int WB_PORTS  = 2,
  parameter int CNT_W     = 2,
  parameter bit ALLOW_WAW = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 issue_valid,
  input  reg_id_t                              src0_id,
  input  reg_id_t                              src1_id,
  input  reg_id_t                              dst_id,
  output logic                                 issue_ready,
  input  logic [WB_PORTS-1:0]                  wb_valid,
  input  logic [WB_PORTS*$bits(reg_id_t)-1:0]  wb_id,
  input  logic                                 flush,
  output logic [NREGS-1:0]                     busy_mask,
  output logic                                 idle,
  output logic                                 err_underflow
);
  localparam int ID_W  = $bits(reg_id_t);
  localparam int DEC_W = $clog2(WB_PORTS + 1);
  localparam int SUM_W = CNT_W + DEC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREGS-1:0][CNT_W-1:0] r_cnt;
  logic                        r_err;

  logic [NREGS-1:0][CNT_W-1:0] w_next;
  logic                        w_underflow;
  logic                        w_fire;
  logic                        w_src0_ok;
  logic                        w_src1_ok;
  logic                        w_dst_ok;
  logic                        w_barrier;
  logic                        w_idle;
  logic [CNT_W-1:0]            w_src0_cnt;
  logic [CNT_W-1:0]            w_src1_cnt;
  logic [CNT_W-1:0]            w_dst_cnt;
  logic [SUM_W-1:0]            w_tot;
  logic [SUM_W-1:0]            w_dec;
  logic [ID_W-1:0]             w_wb_cur;

  assign w_src0_cnt = r_cnt[reg_num(src0_id)];
  assign w_src1_cnt = r_cnt[reg_num(src1_id)];
  assign w_dst_cnt  = r_cnt[reg_num(dst_id)];

  assign w_src0_ok = !reg_in_file(src0_id) || (w_src0_cnt == '0);
  assign w_src1_ok = !reg_in_file(src1_id) || (w_src1_cnt == '0);
  assign w_dst_ok  = !reg_in_file(dst_id) ||
                     (ALLOW_WAW ? (w_dst_cnt != CNT_MAX) : (w_dst_cnt == '0));
  assign w_barrier = (src0_id == rsyscall) || (src1_id == rsyscall) ||
                     (dst_id == rsyscall);
  assign w_idle    = (r_cnt == '0);

  assign issue_ready = !flush && w_src0_ok && w_src1_ok && w_dst_ok &&
                       (!w_barrier || w_idle);
  assign w_fire      = issue_valid && issue_ready;

  // Per-register next count at widened precision so inc and multi-port dec never wrap.
  always_comb begin
    w_next      = r_cnt;
    w_underflow = 1'b0;
    w_tot       = '0;
    w_dec       = '0;
    w_wb_cur    = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_dec = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        w_wb_cur = wb_id[p*ID_W +: ID_W];
        if (wb_valid[p] && reg_in_file(w_wb_cur) && (int'(reg_num(w_wb_cur)) == r))
          w_dec = w_dec + SUM_W'(1);
      end
      w_tot = SUM_W'(r_cnt[r]);
      if (w_fire && reg_in_file(dst_id) && (int'(reg_num(dst_id)) == r))
        w_tot = w_tot + SUM_W'(1);
      if (w_dec > w_tot) begin
        w_next[r]   = '0;
        w_underflow = 1'b1;
      end else begin
        w_next[r] = CNT_W'(w_tot - w_dec);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
      if (w_underflow)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NREGS; r++)
      busy_mask[r] = |r_cnt[r];
  end

  assign idle          = w_idle;
  assign err_underflow = r_err;
endmodule

// File: tb/tb_mop_scoreboard.sv
// Drives a strict-WAW and a relaxed-WAW scoreboard with shared stimulus and
// compares both against a counter-array reference model.
module tb_mop_scoreboard;
  import mop_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        issueValid;
  reg_id_t     src0Id, src1Id, dstId;
  logic [1:0]  wbValid;
  reg_id_t     wbId [2];
  logic [9:0]  wbIdBus;
  logic        flushIn;

  logic        readyS, readyW, idleS, idleW, errS, errW;
  logic [15:0] busyS, busyW;

  int compareCount  = 0;
  int mismatchCount = 0;

  localparam int CNT_MAX = 3;
  int mCnt [2][16];
  bit mErr [2];

  reg_id_t pool [9] = '{rax, rbx, rcx, rdx, r8, rip, rimm, rnil, rsyscall};

  assign wbIdBus = {wbId[1], wbId[0]};

  always #5 clk = ~clk;

  mop_scoreboard #(.NREGS(16), .WB_PORTS(2), .CNT_W(2), .ALLOW_WAW(1'b0)) dutStrict (
    .clk(clk), .reset_n(resetN), .issue_valid(issueValid),
    .src0_id(src0Id), .src1_id(src1Id), .dst_id(dstId), .issue_ready(readyS),
    .wb_valid(wbValid), .wb_id(wbIdBus), .flush(flushIn),
    .busy_mask(busyS), .idle(idleS), .err_underflow(errS)
  );

  mop_scoreboard #(.NREGS(16), .WB_PORTS(2), .CNT_W(2), .ALLOW_WAW(1'b1)) dutWaw (
    .clk(clk), .reset_n(resetN), .issue_valid(issueValid),
    .src0_id(src0Id), .src1_id(src1Id), .dst_id(dstId), .issue_ready(readyW),
    .wb_valid(wbValid), .wb_id(wbIdBus), .flush(flushIn),
    .busy_mask(busyW), .idle(idleW), .err_underflow(errW)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit isTracked(reg_id_t id);
    return !(id inside {rnil, rip, rimm, rv0, rv8, rsyscall});
  endfunction

  function automatic bit mdlIdle(int k);
    for (int r = 0; r < 16; r++)
      if (mCnt[k][r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] mdlBusy(int k);
    logic [15:0] m = '0;
    for (int r = 0; r < 16; r++)
      m[r] = (mCnt[k][r] != 0);
    return m;
  endfunction

  // k=0 is the strict instance, k=1 allows up to CNT_MAX writers per register.
  function automatic bit mdlReady(int k);
    if (flushIn) return 1'b0;
    if (isTracked(src0Id) && mCnt[k][int'(src0Id)] != 0) return 1'b0;
    if (isTracked(src1Id) && mCnt[k][int'(src1Id)] != 0) return 1'b0;
    if (isTracked(dstId)) begin
      if (k == 0 && mCnt[k][int'(dstId)] != 0) return 1'b0;
      if (k == 1 && mCnt[k][int'(dstId)] == CNT_MAX) return 1'b0;
    end
    if ((src0Id == rsyscall || src1Id == rsyscall || dstId == rsyscall) && !mdlIdle(k))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input logic valid, input reg_id_t s0, input reg_id_t s1,
                               input reg_id_t d, input logic [1:0] wbv,
                               input reg_id_t wb0, input reg_id_t wb1,
                               input logic fl, input logic rstn);
    issueValid = valid;
    src0Id     = s0;
    src1Id     = s1;
    dstId      = d;
    wbValid    = wbv;
    wbId[0]    = wb0;
    wbId[1]    = wb1;
    flushIn    = fl;
    resetN     = rstn;
    #1;
    checkOutput("ready_strict", 32'(readyS), 32'(mdlReady(0)));
    checkOutput("ready_waw",    32'(readyW), 32'(mdlReady(1)));
    checkOutput("busy_strict",  32'(busyS),  32'(mdlBusy(0)));
    checkOutput("busy_waw",     32'(busyW),  32'(mdlBusy(1)));
    checkOutput("idle_strict",  32'(idleS),  32'(mdlIdle(0)));
    checkOutput("idle_waw",     32'(idleW),  32'(mdlIdle(1)));
    checkOutput("err_strict",   32'(errS),   32'(mErr[0]));
    checkOutput("err_waw",      32'(errW),   32'(mErr[1]));
  endtask

  // Advances one clock and applies the same edge to the reference model.
  task automatic tick();
    bit rdy [2];
    int nxt [16];
    for (int k = 0; k < 2; k++) rdy[k] = mdlReady(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!resetN) begin
        for (int r = 0; r < 16; r++) mCnt[k][r] = 0;
        mErr[k] = 1'b0;
      end else if (flushIn) begin
        for (int r = 0; r < 16; r++) mCnt[k][r] = 0;
      end else begin
        for (int r = 0; r < 16; r++) nxt[r] = mCnt[k][r];
        if (issueValid && rdy[k] && isTracked(dstId)) nxt[int'(dstId)]++;
        for (int p = 0; p < 2; p++)
          if (wbValid[p] && isTracked(wbId[p])) nxt[int'(wbId[p])]--;
        for (int r = 0; r < 16; r++) begin
          if (nxt[r] < 0) begin
            nxt[r]  = 0;
            mErr[k] = 1'b1;
          end
          mCnt[k][r] = nxt[r];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idleStep();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    tick();
  endtask

  task automatic resetDut();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 0);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) mCnt[k][r] = 0;
      mErr[k] = 1'b0;
    end
    issueValid = 0; src0Id = rnil; src1Id = rnil; dstId = rnil;
    wbValid = 2'b00; wbId[0] = rnil; wbId[1] = rnil; flushIn = 0; resetN = 0;
    @(negedge clk);

    // Reset then RAW
    resetDut();
    applyStimulus(1, rnil, rnil, rax, 2'b00, rnil, rnil, 0, 1);
    checkOutput("rst_idle", 32'(idleS), 32'd1);
    checkOutput("rst_ready", 32'(readyS), 32'd1);
    tick();
    applyStimulus(1, rax, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("raw_stall", 32'(readyS), 32'd0);
    checkOutput("raw_busy", 32'(busyS[0]), 32'd1);
    tick();
    applyStimulus(0, rax, rnil, rnil, 2'b01, rax, rnil, 0, 1);
    checkOutput("raw_no_bypass", 32'(readyS), 32'd0);
    tick();
    applyStimulus(1, rax, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("raw_freed", 32'(readyS), 32'd1);
    checkOutput("raw_idle", 32'(idleS), 32'd1);
    tick();

    // WAW policy
    resetDut();
    applyStimulus(1, rnil, rnil, rbx, 2'b00, rnil, rnil, 0, 1);
    tick();
    applyStimulus(1, rnil, rnil, rbx, 2'b00, rnil, rnil, 0, 1);
    checkOutput("waw_strict_stall", 32'(readyS), 32'd0);
    checkOutput("waw_relaxed_ok", 32'(readyW), 32'd1);
    tick();
    applyStimulus(1, rnil, rnil, rbx, 2'b00, rnil, rnil, 0, 1);
    checkOutput("waw_third_ok", 32'(readyW), 32'd1);
    tick();
    applyStimulus(1, rnil, rnil, rbx, 2'b00, rnil, rnil, 0, 1);
    checkOutput("waw_fourth_stall", 32'(readyW), 32'd0);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b01, rbx, rnil, 0, 1);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b11, rbx, rbx, 0, 1);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("waw_drained", 32'(idleW), 32'd1);
    checkOutput("waw_no_err", 32'(errW), 32'd0);
    tick();

    // Simultaneous issue and writeback
    resetDut();
    applyStimulus(1, rnil, rnil, rcx, 2'b00, rnil, rnil, 0, 1);
    tick();
    applyStimulus(1, rnil, rnil, rcx, 2'b01, rcx, rnil, 0, 1);
    tick();
    applyStimulus(1, rnil, rnil, rcx, 2'b00, rnil, rnil, 0, 1);
    checkOutput("sim_cnt_held", 32'(busyW[1]), 32'd1);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b11, rcx, rcx, 0, 1);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("sim_dual_idle", 32'(idleW), 32'd1);
    checkOutput("sim_dual_noerr", 32'(errW), 32'd0);
    tick();

    // Syscall barrier
    resetDut();
    applyStimulus(1, rnil, rnil, rdi, 2'b00, rnil, rnil, 0, 1);
    tick();
    applyStimulus(1, rsyscall, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("sys_stall", 32'(readyS), 32'd0);
    #1;
    applyStimulus(1, rimm, rip, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("imm_no_stall", 32'(readyS), 32'd1);
    applyStimulus(0, rsyscall, rnil, rnil, 2'b01, rdi, rnil, 0, 1);
    checkOutput("sys_wb_cycle", 32'(readyS), 32'd0);
    tick();
    applyStimulus(1, rsyscall, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("sys_release", 32'(readyS), 32'd1);
    tick();

    // Flush
    resetDut();
    applyStimulus(1, rnil, rnil, rax, 2'b00, rnil, rnil, 0, 1);
    tick();
    applyStimulus(1, rnil, rnil, rdx, 2'b00, rnil, rnil, 0, 1);
    tick();
    applyStimulus(1, rnil, rnil, rsi, 2'b01, rax, rnil, 1, 1);
    checkOutput("flush_ready", 32'(readyS), 32'd0);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("flush_busy", 32'(busyS), 32'd0);
    checkOutput("flush_idle", 32'(idleS), 32'd1);
    checkOutput("flush_err", 32'(errS), 32'd0);
    tick();

    // Underflow
    resetDut();
    applyStimulus(0, rnil, rnil, rnil, 2'b01, r8, rnil, 0, 1);
    tick();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("uf_set", 32'(errS), 32'd1);
    checkOutput("uf_cnt_zero", 32'(idleS), 32'd1);
    tick();
    idleStep();
    idleStep();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("uf_sticky", 32'(errW), 32'd1);
    tick();
    resetDut();
    applyStimulus(0, rnil, rnil, rnil, 2'b00, rnil, rnil, 0, 1);
    checkOutput("uf_cleared", 32'(errS), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    pool[$urandom_range(0, 8)], pool[$urandom_range(0, 8)],
                    pool[$urandom_range(0, 8)],
                    2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)),
                    pool[$urandom_range(0, 8)], pool[$urandom_range(0, 8)],
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 63) != 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
